// File: rtl/tag_checker_mc_pkg.sv
// Shared types for the multi-channel tag-op checker: error codes, opcodes, entry/tag-info layouts.
`ifndef TAG_CHECKER_MC_PKG_SV
`define TAG_CHECKER_MC_PKG_SV

`define TAG_CHECKER_MC_TAG_INFO_S(tag_w) struct packed { logic valid; logic lock; logic [tag_w-1:0] tag; }
`define TAG_CHECKER_MC_ENTRY_S(word_w) struct packed { logic valid; logic [word_w-1:0] data; }

package tag_checker_mc_pkg;

  typedef enum logic [1:0] {
    MISMATCH  = 2'd0,
    ORPHAN    = 2'd1,
    DUPLICATE = 2'd2
  } error_code_e;

  localparam int opcode_width_lp = 6;

  localparam logic [opcode_width_lp-1:0] TAGST = 6'b010000;
  localparam logic [opcode_width_lp-1:0] TAGLV = 6'b010010;
  localparam logic [opcode_width_lp-1:0] TAGLA = 6'b010011;

  // Packet layout, MSB first: {src_id, opcode, addr, data, mask}
  function automatic int pkt_width(input int sid_w, input int addr_w, input int word_w);
    return sid_w + opcode_width_lp + addr_w + word_w + word_w / 8;
  endfunction

endpackage

`endif

// File: rtl/tag_checker_mc_if.sv
// Observed cache request/response bus for all channels; channel 0 occupies the LSBs of every field.
interface tag_checker_mc_if
  import tag_checker_mc_pkg::*;
#(
  parameter int num_ch_p       = 1,
  parameter int src_id_width_p = 4,
  parameter int word_width_p   = 32,
  parameter int addr_width_p   = 32,
  localparam int pkt_width_lp  = pkt_width(src_id_width_p, addr_width_p, word_width_p)
);
  logic [num_ch_p-1:0]                    v_i;
  logic [num_ch_p-1:0]                    yumi_o;
  logic [num_ch_p*pkt_width_lp-1:0]       cache_pkt_i;
  logic [num_ch_p-1:0]                    v_o;
  logic [num_ch_p-1:0]                    yumi_i;
  logic [num_ch_p*word_width_p-1:0]       data_o;
  logic [num_ch_p*(src_id_width_p+1)-1:0] src_id_o;

  modport master (output v_i, yumi_o, cache_pkt_i, v_o, yumi_i, data_o, src_id_o);
  modport slave  (input  v_i, yumi_o, cache_pkt_i, v_o, yumi_i, data_o, src_id_o);
endinterface

// File: rtl/tag_checker_ch.sv
// One channel: shadow tags, expected table by src_id, outstanding count; flags are combinational
// in the handshake cycle. Pure observer, never backpressures.
module tag_checker_ch
  import tag_checker_mc_pkg::*;
#(
  parameter int src_id_width_p        = 4,
  parameter int word_width_p          = 32,
  parameter int addr_width_p          = 32,
  parameter int ways_p                = 2,
  parameter int sets_p                = 4,
  parameter int tag_width_lp          = 25,
  parameter int block_size_in_words_p = 4,
  localparam int pkt_width_lp = pkt_width(src_id_width_p, addr_width_p, word_width_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      en_i,
  input  logic                      req_vld,
  input  logic [pkt_width_lp-1:0]   pkt_dat,
  input  logic                      rsp_vld,
  input  logic [src_id_width_p-1:0] rsp_id,
  input  logic [word_width_p-1:0]   rsp_dat,
  output logic                      rsp_err,
  output error_code_e               rsp_code,
  output logic                      dup_err,
  output logic [src_id_width_p-1:0] dup_id,
  output logic [src_id_width_p:0]   outstanding
);
  localparam int offset_w_lp = $clog2(word_width_p / 8) + $clog2(block_size_in_words_p);
  localparam int index_w_lp  = (sets_p > 1) ? $clog2(sets_p) : 1;
  localparam int way_w_lp    = (ways_p > 1) ? $clog2(ways_p) : 1;
  localparam int data_lsb_lp = word_width_p / 8;
  localparam int addr_lsb_lp = data_lsb_lp + word_width_p;
  localparam int op_lsb_lp   = addr_lsb_lp + addr_width_p;
  localparam int id_lsb_lp   = op_lsb_lp + opcode_width_lp;
  localparam int n_ids_lp    = 2 ** src_id_width_p;
  localparam int cnt_w_lp    = src_id_width_p + 1;

  typedef `TAG_CHECKER_MC_TAG_INFO_S(tag_width_lp) tag_info_s;
  typedef `TAG_CHECKER_MC_ENTRY_S(word_width_p) entry_s;

  tag_info_s shadow_r  [ways_p][sets_p];
  entry_s    exp_tbl_r [n_ids_lp];

  logic [opcode_width_lp-1:0] opcode;
  logic [index_w_lp-1:0]      idx;
  logic [way_w_lp-1:0]        way;
  logic [src_id_width_p-1:0]  req_id;
  tag_info_s                  cur;
  logic [word_width_p-1:0]    exp_dat;
  logic                       is_tag_op;
  logic                       install;
  logic                       chk;
  logic                       hit;
  logic                       retire;
  logic                       unused_pkt;

  assign opcode     = pkt_dat[op_lsb_lp +: opcode_width_lp];
  assign idx        = pkt_dat[addr_lsb_lp + offset_w_lp +: index_w_lp];
  assign way        = pkt_dat[addr_lsb_lp + offset_w_lp + index_w_lp +: way_w_lp];
  assign req_id     = pkt_dat[id_lsb_lp +: src_id_width_p];
  assign cur        = shadow_r[way][idx];
  assign unused_pkt = ^pkt_dat;

  always_comb begin
    exp_dat   = '0;
    is_tag_op = 1'b1;
    case (opcode)
      TAGST:   exp_dat = '0;
      TAGLV:   exp_dat = word_width_p'({cur.lock, cur.valid});
      TAGLA:   exp_dat = (word_width_p'(cur.tag) << (index_w_lp + offset_w_lp))
                       | (word_width_p'(idx) << offset_w_lp);
      default: is_tag_op = 1'b0;
    endcase
  end

  assign install  = req_vld & en_i & is_tag_op;
  assign chk      = rsp_vld & en_i;
  assign hit      = exp_tbl_r[rsp_id].valid;
  assign retire   = chk & hit;
  assign rsp_err  = chk & (~hit | (exp_tbl_r[rsp_id].data != rsp_dat));
  assign rsp_code = hit ? MISMATCH : ORPHAN;
  // An id retired in this same cycle is free again, so reinstalling it is legal.
  assign dup_err  = install & exp_tbl_r[req_id].valid & ~(retire & (rsp_id == req_id));
  assign dup_id   = req_id;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int w = 0; w < ways_p; w++)
        for (int s = 0; s < sets_p; s++)
          shadow_r[w][s] <= '0;
      for (int i = 0; i < n_ids_lp; i++)
        exp_tbl_r[i] <= '0;
      outstanding <= '0;
    end else begin
      if (install && opcode == TAGST)
        shadow_r[way][idx] <= '{valid: pkt_dat[data_lsb_lp + word_width_p - 1],
                                lock:  pkt_dat[data_lsb_lp + word_width_p - 2],
                                tag:   pkt_dat[data_lsb_lp +: tag_width_lp]};
      if (retire)
        exp_tbl_r[rsp_id].valid <= 1'b0;
      if (install)
        exp_tbl_r[req_id] <= '{valid: 1'b1, data: exp_dat};
      outstanding <= outstanding + cnt_w_lp'(install & ~dup_err) - cnt_w_lp'(retire);
    end
  end
endmodule

// File: rtl/tag_checker_mc.sv
// Multi-channel tag-op scoreboard: per-channel checkers, lowest-channel error select, saturating count.
// Error outputs are registered one cycle after the handshake; observes the bus only, no backpressure.
module tag_checker_mc
  import tag_checker_mc_pkg::*;
#(
  parameter int num_ch_p              = 1,
  parameter int src_id_width_p        = 4,
  parameter int word_width_p          = 32,
  parameter int addr_width_p          = 32,
  parameter int ways_p                = 2,
  parameter int sets_p                = 4,
  parameter int tag_width_lp          = 25,
  parameter int block_size_in_words_p = 4,
  parameter int err_cnt_width_p       = 16,
  localparam int ch_w_lp  = (num_ch_p > 1) ? $clog2(num_ch_p) : 1,
  localparam int pkt_w_lp = pkt_width(src_id_width_p, addr_width_p, word_width_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   en_i,
  input  logic                                   clear_i,
  tag_checker_mc_if.slave                        bus,
  output logic                                   error_o,
  output logic [ch_w_lp-1:0]                     error_ch_o,
  output logic [1:0]                             error_code_o,
  output logic [src_id_width_p-1:0]              error_id_o,
  output logic [err_cnt_width_p-1:0]             error_cnt_o,
  output logic [num_ch_p*(src_id_width_p+1)-1:0] outstanding_o,
  output logic                                   idle_o
);
  localparam int cnt_w_lp = err_cnt_width_p + $clog2(2 * num_ch_p + 1) + 1;

  logic [num_ch_p-1:0]       rsp_err;
  logic [num_ch_p-1:0]       dup_err;
  error_code_e               rsp_code [num_ch_p];
  logic [src_id_width_p-1:0] rsp_id   [num_ch_p];
  logic [src_id_width_p-1:0] dup_id   [num_ch_p];

  for (genvar c = 0; c < num_ch_p; c++) begin : g_ch
    assign rsp_id[c] = bus.src_id_o[c*(src_id_width_p+1) +: src_id_width_p];

    tag_checker_ch #(
      .src_id_width_p(src_id_width_p), .word_width_p(word_width_p), .addr_width_p(addr_width_p),
      .ways_p(ways_p), .sets_p(sets_p), .tag_width_lp(tag_width_lp),
      .block_size_in_words_p(block_size_in_words_p)
    ) u_ch (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .en_i        (en_i),
      .req_vld     (bus.v_i[c] & bus.yumi_o[c]),
      .pkt_dat     (bus.cache_pkt_i[c*pkt_w_lp +: pkt_w_lp]),
      .rsp_vld     (bus.v_o[c] & bus.yumi_i[c] & bus.src_id_o[c*(src_id_width_p+1) + src_id_width_p]),
      .rsp_id      (rsp_id[c]),
      .rsp_dat     (bus.data_o[c*word_width_p +: word_width_p]),
      .rsp_err     (rsp_err[c]),
      .rsp_code    (rsp_code[c]),
      .dup_err     (dup_err[c]),
      .dup_id      (dup_id[c]),
      .outstanding (outstanding_o[c*(src_id_width_p+1) +: src_id_width_p+1])
    );
  end

  logic                      sel_vld;
  logic [ch_w_lp-1:0]        sel_ch;
  error_code_e               sel_code;
  logic [src_id_width_p-1:0] sel_id;
  logic [cnt_w_lp-1:0]       n_err;
  logic [cnt_w_lp-1:0]       cnt_sum;
  logic [err_cnt_width_p-1:0] cnt_next;

  // Scan from the top so the lowest erroring channel is the one left selected.
  always_comb begin
    sel_vld  = 1'b0;
    sel_ch   = '0;
    sel_code = MISMATCH;
    sel_id   = '0;
    n_err    = '0;
    for (int c = num_ch_p - 1; c >= 0; c--) begin
      n_err = n_err + cnt_w_lp'(rsp_err[c]) + cnt_w_lp'(dup_err[c]);
      if (rsp_err[c] || dup_err[c]) begin
        sel_vld  = 1'b1;
        sel_ch   = ch_w_lp'(c);
        sel_code = rsp_err[c] ? rsp_code[c] : DUPLICATE;
        sel_id   = rsp_err[c] ? rsp_id[c] : dup_id[c];
      end
    end
    cnt_sum  = (clear_i ? '0 : cnt_w_lp'(error_cnt_o)) + n_err;
    cnt_next = (|cnt_sum[cnt_w_lp-1:err_cnt_width_p]) ? '1 : cnt_sum[err_cnt_width_p-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      error_o      <= 1'b0;
      error_ch_o   <= '0;
      error_code_o <= '0;
      error_id_o   <= '0;
      error_cnt_o  <= '0;
    end else begin
      error_o      <= sel_vld;
      error_ch_o   <= sel_ch;
      error_code_o <= sel_code;
      error_id_o   <= sel_id;
      error_cnt_o  <= cnt_next;
    end
  end

  assign idle_o = ~|outstanding_o;
endmodule
